// File: rtl/stack_pkg.sv
// stack_pkg: shared types and constants for the data stack.
//   stack_state_e : control FSM states (IDLE, POP_RD, POP_RESP)
//   OP_PUSH/OP_POP: encodings of req_op
package stack_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP_RD   = 2'd1,
        POP_RESP = 2'd2
    } stack_state_e;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x DATA_BITS storage for the data stack.
//   clk   : write clock
//   we    : write enable (sync)
//   waddr : write index
//   wdata : write word
//   raddr : async read index (the stack top)
//   rdata : word at raddr
// Contents are intentionally not reset.
module stack_ram
    import stack_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: data stack with valid/ready push/pop request port and pop response port.
//   clk, rst_n          : clock, synchronous active-low reset
//   clear               : synchronous flush (empties stack, aborts pending pop)
//   req_valid/req_ready : request handshake; req_op 1=push 0=pop; req_data push operand
//   resp_valid/resp_ready/resp_data : pop result handshake
//   sp, tos             : top index and top word (0 when empty)
//   count, empty, full  : occupancy
//   err_overflow/err_underflow : one-cycle pulses on refused push/pop
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [DATA_BITS-1:0] req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic [ADDR_BITS-1:0] sp,
    output logic [DATA_BITS-1:0] tos,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam logic [ADDR_BITS:0]   FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    stack_state_e         state_r, state_n;
    logic [ADDR_BITS:0]   count_r, count_n;
    logic                 resp_valid_r, resp_valid_n;
    logic [DATA_BITS-1:0] resp_data_r, resp_data_n;
    logic                 err_ov_r, err_ov_n;
    logic                 err_un_r, err_un_n;

    logic                 empty_s, full_s, req_ready_s, accept_s, we_s, ram_we_s;
    logic [ADDR_BITS-1:0] sp_s;
    logic [DATA_BITS-1:0] rd_data_s;

    assign empty_s     = (count_r == {(ADDR_BITS+1){1'b0}});
    assign full_s      = (count_r == FULL_CNT);
    assign req_ready_s = (state_r == IDLE) & ~clear;
    assign accept_s    = req_valid & req_ready_s;
    // Low bits minus one wrap to DEPTH-1 when full, which is the correct top index.
    assign sp_s        = empty_s ? {ADDR_BITS{1'b0}} : (count_r[ADDR_BITS-1:0] - ADDR_ONE);
    // A write on a reset edge would be harmless, but keep the array untouched then.
    assign ram_we_s    = we_s & rst_n;

    stack_ram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (count_r[ADDR_BITS-1:0]),
        .wdata (req_data),
        .raddr (sp_s),
        .rdata (rd_data_s)
    );

    // Next-state and next-output decode for request handling.
    always_comb begin
        state_n      = state_r;
        count_n      = count_r;
        resp_valid_n = resp_valid_r;
        resp_data_n  = resp_data_r;
        err_ov_n     = 1'b0;
        err_un_n     = 1'b0;
        we_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_op == OP_PUSH) begin
                        if (full_s) begin
                            err_ov_n = 1'b1;
                        end else begin
                            we_s    = 1'b1;
                            count_n = count_r + CNT_ONE;
                        end
                    end else begin
                        if (empty_s) begin
                            err_un_n = 1'b1;
                        end else begin
                            state_n = POP_RD;
                        end
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            POP_RD: begin
                // sp already points at count-1, so the read port holds the popped word.
                resp_data_n  = rd_data_s;
                count_n      = count_r - CNT_ONE;
                resp_valid_n = 1'b1;
                state_n      = POP_RESP;
            end
            POP_RESP: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    state_n      = IDLE;
                end else begin
                    resp_valid_n = 1'b1;
                end
            end
            default: begin
                state_n      = IDLE;
                resp_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset beats clear beats request handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= {(ADDR_BITS+1){1'b0}};
            resp_valid_r <= 1'b0;
            resp_data_r  <= {DATA_BITS{1'b0}};
            err_ov_r     <= 1'b0;
            err_un_r     <= 1'b0;
        end else if (clear) begin
            state_r      <= IDLE;
            count_r      <= {(ADDR_BITS+1){1'b0}};
            resp_valid_r <= 1'b0;
            err_ov_r     <= 1'b0;
            err_un_r     <= 1'b0;
        end else begin
            state_r      <= state_n;
            count_r      <= count_n;
            resp_valid_r <= resp_valid_n;
            resp_data_r  <= resp_data_n;
            err_ov_r     <= err_ov_n;
            err_un_r     <= err_un_n;
        end
    end

    assign req_ready     = req_ready_s;
    assign resp_valid    = resp_valid_r;
    assign resp_data     = resp_data_r;
    assign sp            = sp_s;
    assign tos           = empty_s ? {DATA_BITS{1'b0}} : rd_data_s;
    assign count         = count_r;
    assign empty         = empty_s;
    assign full          = full_s;
    assign err_overflow  = err_ov_r;
    assign err_underflow = err_un_r;

endmodule
